// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment patterns, blank code and scan FSM encoding
package seg_pkg;

  localparam logic [3:0] BLANK = 4'hF;

  // Active-high abcdefg patterns written g..a (bit6..bit0); entry i is digit i.
  localparam logic [6:0] PAT_BLANK = 7'b0000000;
  localparam logic [9:0][6:0] SEG_PAT = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// rtl/seg_pattern_lookup.sv - maps an active-high segment pattern to its digit value
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       hit
);

  always_comb begin
    value = BLANK;
    hit   = 1'b0;
    if (pattern == PAT_BLANK) begin
      hit = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_PAT[i]) begin
        value = 4'(i);
        hit   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounced decoder for a multiplexed 7-segment scan bus
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [4*NUM_DIGITS-1:0] frame,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    bad_pattern,
  input  logic                    clr_err
);

  localparam int CW = 8;

  logic [6:0]              seg_r, seg_prev, seg_on;
  logic [NUM_DIGITS-1:0]   an_r, an_prev, sel, seen, cap_mask;
  scan_state_t             state, state_nx;
  logic [CW-1:0]           count, count_nx;
  logic                    capture, qualified, changed, complete_now;
  logic [3:0]              lk_val;
  logic                    lk_hit;
  logic [4*NUM_DIGITS-1:0] digits_nx;

  assign seg_on    = ~seg_r;
  assign sel       = ~an_r;
  assign qualified = $onehot(sel);
  assign changed   = (seg_r != seg_prev) || (an_r != an_prev);

  // Input stage plus a one-sample history used for the stability comparison.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r    <= '1;
      an_r     <= '1;
      seg_prev <= '1;
      an_prev  <= '1;
    end else begin
      seg_r    <= seg_n;
      an_r     <= an_n;
      seg_prev <= seg_r;
      an_prev  <= an_r;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_WAIT;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    capture  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (qualified) begin
          state_nx = ST_COUNT;
          count_nx = 8'd1;
        end else begin
          count_nx = '0;
        end
      end
      ST_COUNT: begin
        if (!qualified) begin
          state_nx = ST_WAIT;
          count_nx = '0;
        end else if (changed) begin
          count_nx = 8'd1;
        end else if (count == CW'(STABLE_CYCLES - 1)) begin
          capture  = 1'b1;
          state_nx = ST_HELD;
          count_nx = CW'(STABLE_CYCLES);
        end else begin
          count_nx = count + 8'd1;
        end
      end
      ST_HELD: begin
        if (!qualified) begin
          state_nx = ST_WAIT;
          count_nx = '0;
        end else if (changed) begin
          state_nx = ST_COUNT;
          count_nx = 8'd1;
        end
      end
      default: begin
        state_nx = ST_WAIT;
        count_nx = '0;
      end
    endcase
  end

  seg_pattern_lookup u_lookup (
    .pattern (seg_on),
    .value   (lk_val),
    .hit     (lk_hit)
  );

  assign cap_mask     = (capture && lk_hit) ? sel : '0;
  assign complete_now = (&(seen | cap_mask)) && !(&seen);

  always_comb begin
    digits_nx = digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mask[i]) digits_nx[4*i +: 4] = lk_val;
    end
  end

  // A pending full scan waits in seen until the previous frame is consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits      <= {NUM_DIGITS{BLANK}};
      frame       <= {NUM_DIGITS{BLANK}};
      seen        <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      digits <= digits_nx;
      seen   <= seen | cap_mask;
      if (capture && !lk_hit) begin
        bad_pattern <= 1'b1;
      end else if (clr_err) begin
        bad_pattern <= 1'b0;
      end
      if (frame_valid) begin
        if (frame_ready) begin
          if (complete_now) begin
            frame <= digits_nx;
            seen  <= '0;
          end else begin
            frame_valid <= 1'b0;
          end
        end
      end else if (&seen) begin
        frame       <= digits_nx;
        frame_valid <= 1'b1;
        seen        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [6:0]  seg_n = '1;
  logic [3:0]  an_n = '1;
  logic        frame_ready = 1'b1;
  logic        clr_err = 1'b0;
  logic [15:0] digits, frame;
  logic        frame_valid, bad_pattern;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .bad_pattern (bad_pattern),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int v);
    case (v)
      0: pat = 7'b0111111;
      1: pat = 7'b0000110;
      2: pat = 7'b1011011;
      3: pat = 7'b1001111;
      4: pat = 7'b1100110;
      5: pat = 7'b1101101;
      6: pat = 7'b1111101;
      7: pat = 7'b0000111;
      8: pat = 7'b1111111;
      9: pat = 7'b1101111;
      default: pat = 7'b0000000;
    endcase
  endfunction

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg_on;
    int         hold;
    logic       hit;
    logic [3:0] val;
    logic       bad;
  } vec_t;

  vec_t        tbl[15];
  logic [15:0] dq[$];
  logic [15:0] fq[$];
  bit          mon_en = 1'b0;
  logic [15:0] last_digits = '1;
  logic        last_fv = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (digits !== last_digits) begin
        if (dq.size() == 0) chk("digits_unexpected", 32'(digits), 32'(last_digits));
        else chk("digits_scoreboard", 32'(digits), 32'(dq.pop_front()));
      end
      if (frame_valid && !last_fv) begin
        if (fq.size() == 0) chk("frame_unexpected", 32'(frame_valid), 32'd0);
        else chk("frame_scoreboard", 32'(frame), 32'(fq.pop_front()));
      end
    end
    last_digits = digits;
    last_fv     = frame_valid;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] on, input int n);
    an_n  = an;
    seg_n = ~on;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_digits"}, 32'(digits), 32'hFFFF);
    chk({tag, "_frame"}, 32'(frame), 32'hFFFF);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_bad"}, 32'(bad_pattern), 32'd0);
  endtask

  logic [15:0] model_digits;
  logic [3:0]  model_seen;
  logic        model_bad;

  initial begin
    tbl[0]  = '{4'b1110, pat(0), 6, 1'b1, 4'h0, 1'b0};
    tbl[1]  = '{4'b1101, pat(9), 6, 1'b1, 4'h9, 1'b0};
    tbl[2]  = '{4'b1011, pat(8), 6, 1'b1, 4'h8, 1'b0};
    tbl[3]  = '{4'b0111, pat(7), 6, 1'b1, 4'h7, 1'b0};
    tbl[4]  = '{4'b1110, pat(5), 6, 1'b1, 4'h5, 1'b0};
    tbl[5]  = '{4'b1110, pat(6), 3, 1'b0, 4'h0, 1'b0};
    tbl[6]  = '{4'b1101, 7'b0000000, 6, 1'b1, 4'hF, 1'b0};
    tbl[7]  = '{4'b1011, 7'b1110000, 6, 1'b0, 4'h0, 1'b1};
    tbl[8]  = '{4'b0111, pat(2), 6, 1'b1, 4'h2, 1'b0};
    tbl[9]  = '{4'b1011, pat(4), 6, 1'b1, 4'h4, 1'b0};
    tbl[10] = '{4'b1110, pat(1), 6, 1'b1, 4'h1, 1'b0};
    tbl[11] = '{4'b1100, pat(3), 10, 1'b0, 4'h0, 1'b0};
    tbl[12] = '{4'b1111, pat(3), 3, 1'b0, 4'h0, 1'b0};
    tbl[13] = '{4'b1101, pat(3), 6, 1'b1, 4'h3, 1'b0};
    tbl[14] = '{4'b0111, pat(6), 6, 1'b1, 4'h6, 1'b0};

    #1 reset_n = 1'b0;
    #2 chk_reset_values("reset0");
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    model_digits = 16'hFFFF;
    model_seen   = '0;
    model_bad    = 1'b0;
    for (int k = 0; k < 15; k++) begin
      int          idx;
      logic [15:0] nd;
      idx = 0;
      for (int b = 0; b < 4; b++) if (!tbl[k].an[b]) idx = b;
      if (tbl[k].hit) begin
        nd = model_digits;
        nd[idx*4 +: 4] = tbl[k].val;
        if (nd != model_digits) dq.push_back(nd);
        model_digits    = nd;
        model_seen[idx] = 1'b1;
        if (&model_seen) begin
          fq.push_back(model_digits);
          model_seen = '0;
        end
      end
      if (tbl[k].bad) model_bad = 1'b1;
      drive(tbl[k].an, tbl[k].seg_on, tbl[k].hold);
      chk($sformatf("vec%0d_digits", k), 32'(digits), 32'(model_digits));
      chk($sformatf("vec%0d_bad", k), 32'(bad_pattern), 32'(model_bad));
    end
    repeat (3) @(negedge clk);
    chk("digit_queue_drained", 32'(dq.size()), 32'd0);
    chk("frame_queue_drained", 32'(fq.size()), 32'd0);
    mon_en = 1'b0;

    reset_n = 1'b0;
    #1 chk_reset_values("reset1");
    @(negedge clk);
    reset_n     = 1'b1;
    frame_ready = 1'b0;

    an_n  = 4'b1110;
    seg_n = ~pat(3);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("latency_edge%0d", k), 32'(digits[3:0]), (k >= 5) ? 32'h3 : 32'hF);
    end
    chk("latency_no_bad", 32'(bad_pattern), 32'd0);
    @(negedge clk);

    drive(4'b1110, pat(1), 6);
    drive(4'b1101, pat(2), 6);
    drive(4'b1011, pat(3), 6);
    an_n  = 4'b0111;
    seg_n = ~pat(4);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        chk("scan_digits", 32'(digits), 32'h4321);
        chk("scan_valid_before", 32'(frame_valid), 32'd0);
      end
      if (k == 6) begin
        chk("scan_valid", 32'(frame_valid), 32'd1);
        chk("scan_frame", 32'(frame), 32'h4321);
      end
    end
    @(negedge clk);

    drive(4'b1110, pat(5), 6);
    drive(4'b1101, pat(6), 6);
    drive(4'b1011, pat(7), 6);
    drive(4'b0111, pat(8), 6);
    chk("bp_digits", 32'(digits), 32'h8765);
    chk("bp_frame_held", 32'(frame), 32'h4321);
    chk("bp_valid_held", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_valid_drop", 32'(frame_valid), 32'd0);
    @(negedge clk);
    frame_ready = 1'b0;
    @(posedge clk);
    #1 chk("bp_valid_again", 32'(frame_valid), 32'd1);
    chk("bp_frame_new", 32'(frame), 32'h8765);
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_consumed", 32'(frame_valid), 32'd0);
    @(negedge clk);
    frame_ready = 1'b0;

    drive(4'b1110, pat(9), 3);
    drive(4'b1111, pat(9), 6);
    chk("short_hold_digits", 32'(digits), 32'h8765);

    drive(4'b1101, 7'b1110000, 6);
    chk("bad_set", 32'(bad_pattern), 32'd1);
    chk("bad_digits", 32'(digits), 32'h8765);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("bad_cleared", 32'(bad_pattern), 32'd0);

    an_n    = 4'b1011;
    seg_n   = ~7'b1110000;
    clr_err = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("set_wins_edge%0d", k), 32'(bad_pattern), (k == 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    clr_err = 1'b0;

    drive(4'b1100, pat(7), 10);
    chk("multi_strobe_digits", 32'(digits), 32'h8765);
    an_n  = 4'b1110;
    seg_n = ~pat(2);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_values("reset_async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1 chk($sformatf("post_reset_edge%0d", k), 32'(digits), (k >= 5) ? 32'hFFF2 : 32'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed digit positions (1..8).
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples a pattern must show before it is captured (2..255).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port seg_n  input  7  meaning the active-low segment bus, bit0=a .. bit6=g.
REQ-006 SHALL have port an_n  input  NUM_DIGITS  meaning the active-low digit strobes; exactly one bit low selects a digit.
REQ-007 SHALL have port digits  output  4*NUM_DIGITS  meaning the live decoded values, digit i at [4i+3:4i].
REQ-008 SHALL have port frame  output  4*NUM_DIGITS  meaning the snapshot of digits taken at frame completion.
REQ-009 SHALL have port frame_valid  output  1  meaning frame holds a complete, unconsumed snapshot.
REQ-010 SHALL have port frame_ready  input  1  meaning the consumer accepts the frame.
REQ-011 SHALL have port bad_pattern  output  1  meaning a sticky flag set when an unrecognised stable pattern is seen.
REQ-012 SHALL have port clr_err  input  1  meaning a synchronous clear for bad_pattern.

Function
REQ-013 SHALL register seg_n and an_n in one input stage, and SHALL feed only the registered copies to all downstream logic.
REQ-014 SHALL treat a sample as qualified only when the registered an_n has exactly one bit low; zero or multiple low bits SHALL reset the stability count to 0.
REQ-015 SHALL run an FSM with states WAIT, COUNT and HELD, where:
- WAIT -> COUNT on a qualified sample.
- COUNT increments while the sample equals the previous one, and returns to COUNT with count=1 on any change.
- Reaching STABLE_CYCLES identical qualified samples SHALL perform one capture and enter HELD.
- HELD -> COUNT (count=1) on any sample change, or -> WAIT on an unqualified sample.
- HELD SHALL NOT recapture.
REQ-016 SHALL decode the inverted sample abcdefg with this table, giving values 0-9:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- blank 0000000 SHALL decode to 4'hF.
REQ-017 SHALL, on capture of a recognised pattern, write its value into digits slot i for the low an_n bit i, and set seen[i].
REQ-018 SHALL, on capture of an unrecognised pattern, leave digits and seen unchanged and set bad_pattern; if clr_err coincides with such a capture, set SHALL win.
REQ-019 SHALL update digits exactly STABLE_CYCLES+1 clock edges after the first edge at which a new stable pattern is present on the inputs.
REQ-020 SHALL, when seen becomes all-ones and frame_valid=0, on the next edge:
- copy digits (including the capture from that cycle) into frame;
- set frame_valid;
- clear seen.
REQ-021 SHALL hold frame and frame_valid constant while frame_valid=1 and frame_ready=0; captures SHALL continue to update digits and seen.
REQ-022 SHALL clear frame_valid on an edge where frame_valid=1 and frame_ready=1; a frame completing on that same edge SHALL load immediately, keeping frame_valid=1.
REQ-023 SHALL treat frame_ready as don't-care while frame_valid=0.

Reset
REQ-024 SHALL, on reset_n low and independent of clk, set:
- input stage to all-ones (blank, no strobe);
- FSM to WAIT and count to 0;
- seen=0, digits=all 4'hF, frame=all 4'hF;
- frame_valid=0, bad_pattern=0.
REQ-025 SHALL, on reset asserted mid-capture or mid-frame, discard the partial count and seen state, with no capture on the release edge.
REQ-026 SHALL release reset synchronously to clk, with first sampling on the first edge after release.

Structure
REQ-027 SHALL place the segment-pattern constants (10 digits plus blank), the BLANK code 4'hF and the FSM state encoding in a shared package seg_pkg.
REQ-028 SHALL implement the pattern-to-value lookup as sub-module seg_pattern_lookup (7-bit in, 4-bit value, 1-bit hit), and SHALL instantiate it exactly once.

Verification
REQ-029 SHALL cover: seg_n=~7'b1001111 with an_n=4'b1110 held 6 cycles -> digits[3:0]=3 exactly 5 edges after application, single capture, no bad_pattern.
REQ-030 SHALL cover: scan 1,2,3,4 on an_n 1110,1101,1011,0111, 6 cycles each -> frame=16'h4321 and frame_valid=1 one edge after digit 3 captures.
REQ-031 SHALL cover: frame_valid=1 with frame_ready=0 while a rescan with 5,6,7,8 runs -> frame stays 16'h4321 and digits=16'h8765; on frame_ready=1, frame_valid drops for one cycle, then reasserts with 16'h8765 on the next full scan.
REQ-032 SHALL cover: pattern held only 3 cycles, then changed -> no capture and digits unchanged.
REQ-033 SHALL cover: stable pattern ~7'b1110000 -> bad_pattern=1 and digit unchanged; clr_err pulse -> bad_pattern=0.
REQ-034 SHALL cover: an_n=4'b1100 held 10 cycles -> no capture; then reset_n pulse in COUNT -> all outputs return to the REQ-024 values asynchronously.
